vga_scanout: RTL and testbench



---
 rtl/vga_scanout.sv | 231 +++++++++++++++++++++++
 tb/tb_vga_scanout.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 160x120 12-bit framebuffer with a single-pixel write port,
// scanned out as 640x480@60 Hz VGA with every logical pixel drawn as a 4x4
// block. The DAC pixel clock is half the 50 MHz system clock. A pixel tick
// is a system clock on which the phase register is 1.
//
// Optional feature macro: FB_CLEAR_EN. When it is defined, a sequencer
// clears the whole framebuffer after reset release and raises busy while
// it runs. Host writes are ignored during the clear.
module vga_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        wr_en,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [11:0] wr_color,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_clk,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

    // Scan state and the read pipeline.
    logic        r_ph;
    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic [14:0] r_addr;
    logic        r_vis1;
    logic        r_hs1;
    logic        r_vs1;
    logic [11:0] r_rgb;
    logic        r_blank_n;
    logic        r_hs;
    logic        r_vs;
    logic        r_frame_start;

    // The framebuffer is deliberately not reset.
    logic [11:0] r_mem [0:FB_DEPTH-1];

    logic        w_vis;
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_frame_end;
    logic [14:0] w_raddr;
    logic        w_host_ok;
    logic [14:0] w_host_addr;
    logic        w_we;
    logic [14:0] w_waddr;
    logic [11:0] w_wdata;

    // Decode the current counter position into visibility, syncs and read address.
    always_comb begin
        w_vis       = (r_hcount < 10'(H_VIS)) && (r_vcount < 10'(V_VIS));
        w_hs_n      = !((r_hcount >= 10'(H_VIS + H_FP)) &&
                        (r_hcount <  10'(H_VIS + H_FP + H_SYNC)));
        w_vs_n      = !((r_vcount >= 10'(V_VIS + V_FP)) &&
                        (r_vcount <  10'(V_VIS + V_FP + V_SYNC)));
        w_frame_end = (r_hcount == 10'(H_TOTAL - 1)) && (r_vcount == 10'(V_TOTAL - 1));
        w_raddr     = 15'(r_vcount[9:2]) * 15'd160 + 15'(r_hcount[9:2]);
    end

    // Host write decode: out-of-range coordinates are dropped rather than aliased.
    always_comb begin
        w_host_ok   = wr_en && (wr_x < 8'd160) && (wr_y < 7'd120);
        w_host_addr = 15'(wr_y) * 15'd160 + 15'(wr_x);
    end

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {
        CLR_ARM  = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    clr_state_t  r_clr_state;
    clr_state_t  w_clr_next;
    logic [14:0] r_clr_addr;
    logic [14:0] w_clr_addr_next;
    logic        r_busy;

    // Clear sequencer state register; arms on reset, runs on the first clock after release.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_clr_state <= CLR_ARM;
            r_clr_addr  <= 15'd0;
            r_busy      <= 1'b0;
        end else begin
            r_clr_state <= w_clr_next;
            r_clr_addr  <= w_clr_addr_next;
            r_busy      <= (w_clr_next == CLR_RUN);
        end
    end

    // Clear sequencer next state: one address per clock up to the last framebuffer word.
    always_comb begin
        w_clr_next      = r_clr_state;
        w_clr_addr_next = r_clr_addr;
        case (r_clr_state)
            CLR_ARM: begin
                w_clr_next      = CLR_RUN;
                w_clr_addr_next = 15'd0;
            end
            CLR_RUN: begin
                if (r_clr_addr == 15'(FB_DEPTH - 1)) begin
                    w_clr_next = CLR_DONE;
                end else begin
                    w_clr_addr_next = r_clr_addr + 15'd1;
                end
            end
            CLR_DONE: begin
                w_clr_next = CLR_DONE;
            end
            default: begin
                w_clr_next      = CLR_DONE;
                w_clr_addr_next = 15'd0;
            end
        endcase
    end

    // Write port mux: the clearing sequencer owns the port while it runs.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = 15'd0;
        w_wdata = 12'h000;
        if (r_clr_state == CLR_RUN) begin
            w_we    = 1'b1;
            w_waddr = r_clr_addr;
            w_wdata = 12'h000;
        end else begin
            w_we    = w_host_ok;
            w_waddr = w_host_addr;
            w_wdata = wr_color;
        end
    end

    assign busy = r_busy;
`else
    // Write port driven by the host only.
    always_comb begin
        w_we    = w_host_ok;
        w_waddr = w_host_addr;
        w_wdata = wr_color;
    end

    assign busy = 1'b0;
`endif

    // Framebuffer write port; accepted on any clock, independent of scan phase.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Pixel phase, scan counters and frame-start pulse.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ph          <= 1'b0;
            r_hcount      <= 10'd0;
            r_vcount      <= 10'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_ph          <= !r_ph;
            r_frame_start <= r_ph && w_frame_end;
            if (r_ph) begin
                if (r_hcount == 10'(H_TOTAL - 1)) begin
                    r_hcount <= 10'd0;
                    if (r_vcount == 10'(V_TOTAL - 1)) begin
                        r_vcount <= 10'd0;
                    end else begin
                        r_vcount <= r_vcount + 10'd1;
                    end
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    // Address stage and RAM output stage; syncs and blank ride alongside so they stay aligned.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr    <= 15'd0;
            r_vis1    <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_rgb     <= 12'h000;
            r_blank_n <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
        end else if (r_ph) begin
            r_addr    <= w_vis ? w_raddr : 15'd0;
            r_vis1    <= w_vis;
            r_hs1     <= w_hs_n;
            r_vs1     <= w_vs_n;
            r_rgb     <= r_vis1 ? r_mem[r_addr] : 12'h000;
            r_blank_n <= r_vis1;
            r_hs      <= r_hs1;
            r_vs      <= r_vs1;
        end
    end

    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_clk     = r_ph;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout, run on a shrunk raster so several frames
// fit in a short run: 112 ticks per line (96 visible, sync ticks 100..107)
// and 44 lines per frame (40 visible, sync lines 41..42).
// Output for tick position k is sampled 1 ns after clock edge 2k+4,
// where edges are counted from reset release.
module tb_vga_scanout;

    localparam int HT = 112;
    localparam int VT = 44;
    localparam int FC = 2 * HT * VT;   // 9856 clocks per frame
`ifdef FB_CLEAR_EN
    localparam int F0 = 2;             // first frame after the power-up clear
`else
    localparam int F0 = 0;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_x = 8'd0;
    logic [6:0]  wr_y = 7'd0;
    logic [11:0] wr_color = 12'h000;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n, vga_clk, frame_start, busy;
    logic [11:0] rgb;

    int cyc;
    int errors = 0;
    int checks = 0;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_scanout #(
        .H_VIS(96), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(40), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .wr_color(wr_color), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
        .vga_clk(vga_clk), .frame_start(frame_start), .busy(busy)
    );

    always #5 clock = ~clock;

    // Clock edges since the last reset release.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic goto(input int e);
        if (cyc > e) chk("late", cyc, e);
        while (cyc < e) step();
    endtask

    task automatic do_write(input logic [7:0] x, input logic [6:0] y, input logic [11:0] c);
        wr_en = 1'b1; wr_x = x; wr_y = y; wr_color = c;
        step();
        wr_en = 1'b0;
    endtask

    function automatic int at(input int h, input int v, input int f);
        return f * FC + 2 * (v * HT + h) + 4;
    endfunction

    initial begin
        int x_fs;
        int w0;
        int hs_lo, vs_lo, bl_hi, fs_n, nz;

        repeat (5) @(posedge clock);
        #1;
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_blank_n", vga_blank_n, 0);
        chk("rst_rgb", rgb, 12'h000);
        chk("rst_busy", busy, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_vga_clk", vga_clk, 0);

        @(negedge clock);
        resetn = 1'b1;
        step();
`ifdef FB_CLEAR_EN
        chk("busy_first_clock", busy, 1);
        goto(19201);
        chk("busy_released", busy, 0);
`endif
        do_write(8'd0, 7'd0, 12'h00F);
        do_write(8'd5, 7'd7, 12'hF0A);
        do_write(8'd4, 7'd7, 12'h111);
        do_write(8'd6, 7'd7, 12'h222);
        do_write(8'd5, 7'd6, 12'h333);
        do_write(8'd5, 7'd8, 12'h444);
        do_write(8'd0, 7'd1, 12'h123);
        do_write(8'd160, 7'd0, 12'hFFF);   // would alias to (0,1) if not dropped

        goto(at(0, 4, F0));    chk("oor_keeps_0_1", rgb, 12'h123);
        goto(at(100, 5, F0));  chk("hblank_rgb", rgb, 12'h000);
                               chk("hblank_blank_n", vga_blank_n, 0);
        goto(at(20, 27, F0));  chk("above_5_7", rgb, 12'h333);
        goto(at(19, 28, F0));  chk("left_5_7", rgb, 12'h111);
        goto(at(20, 28, F0));  chk("pix_20_28", rgb, 12'hF0A);
                               chk("vis_blank_n", vga_blank_n, 1);
        goto(at(24, 28, F0));  chk("right_5_7", rgb, 12'h222);
        goto(at(99, 29, F0));  chk("hs_before", vga_hs, 1);
        goto(at(100, 29, F0)); chk("hs_first", vga_hs, 0);
        goto(at(107, 29, F0)); chk("hs_last", vga_hs, 0);
        goto(at(108, 29, F0)); chk("hs_after", vga_hs, 1);
        goto(at(23, 31, F0));  chk("pix_23_31", rgb, 12'hF0A);
        goto(at(20, 32, F0));  chk("below_5_7", rgb, 12'h444);
        goto(at(0, 40, F0));   chk("vs_before", vga_vs, 1);
                               chk("vblank_blank_n", vga_blank_n, 0);
        goto(at(10, 40, F0));  chk("vblank_rgb", rgb, 12'h000);
        goto(at(0, 41, F0));   chk("vs_first", vga_vs, 0);
        goto(at(0, 42, F0));   chk("vs_last", vga_vs, 0);
        goto(at(0, 43, F0));   chk("vs_after", vga_vs, 1);

        x_fs = (F0 + 1) * FC;
        goto(x_fs - 1); chk("fs_before", frame_start, 0);
        goto(x_fs);     chk("fs_pulse", frame_start, 1);
        goto(x_fs + 1); chk("fs_after", frame_start, 0);

        // Write address 0 on the very clock the scan reads it for (0,0).
        goto(x_fs + 3);
        do_write(8'd0, 7'd0, 12'h0F0);
        chk("collision_old", rgb, 12'h00F);
        goto(x_fs + 6); chk("collision_next_read", rgb, 12'h0F0);
        goto((F0 + 2) * FC + 4); chk("collision_next_frame", rgb, 12'h0F0);

        w0 = (F0 + 2) * FC + 8;
        hs_lo = 0; vs_lo = 0; bl_hi = 0; fs_n = 0;
        for (int i = 0; i < FC; i++) begin
            goto(w0 + i);
            if (!vga_hs) hs_lo++;
            if (!vga_vs) vs_lo++;
            if (vga_blank_n) bl_hi++;
            if (frame_start) fs_n++;
        end
        chk("frame_hs_low_clocks", hs_lo, 44 * 16);
        chk("frame_vs_low_clocks", vs_lo, 2 * 224);
        chk("frame_blank_n_clocks", bl_hi, 40 * 192);
        chk("frame_start_count", fs_n, 1);

        // Asynchronous reset in the middle of a visible line.
        goto(w0 + FC + 1);
        chk("pre_rst_clk", vga_clk, 1);
        chk("pre_rst_blank_n", vga_blank_n, 1);
        chk("pre_rst_rgb", rgb, 12'h0F0);
        #1 resetn = 1'b0;
        #1;
        chk("async_rst_clk", vga_clk, 0);
        chk("async_rst_blank_n", vga_blank_n, 0);
        chk("async_rst_rgb", rgb, 12'h000);

`ifdef FB_CLEAR_EN
        repeat (5) @(posedge clock);
        #1;
        chk("clr_rst_busy", busy, 0);
        @(negedge clock);
        resetn = 1'b1;
        step();
        chk("clr_busy_start", busy, 1);
        goto(100);
        do_write(8'd5, 7'd7, 12'hABC);     // must be ignored while busy
        goto(19200); chk("clr_busy_last", busy, 1);
        goto(19201); chk("clr_busy_end", busy, 0);
        nz = 0; bl_hi = 0;
        for (int i = 0; i < FC; i++) begin
            goto(2 * FC + 4 + i);
            if (rgb != 12'h000) nz++;
            if (vga_blank_n) bl_hi++;
            if (cyc == at(20, 28, 2)) chk("clr_pix_20_28", rgb, 12'h000);
        end
        chk("clr_frame_nonblack", nz, 0);
        chk("clr_frame_blank_n", bl_hi, 40 * 192);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
